devre_sweep_ctrl: RTL and testbench
===================================

// Module: devre_sweep_ctrl
// PURPOSE
//  Sequencer and owner of the 3-input gate network "devre" (inputs A,B,C; output F).
//  Drives A/B/C on behalf of two requesters: a full truth-table sweep (start/done) and single-vector evaluation (eval_req/eval_ack).
//  Sweep records F for all 8 vectors, compares against a golden table and flags pass.
//  Sits between the control host and the combinational devre instance; nothing else drives devre.
// PARAMETERS
//  SETTLE_CYC  2      cycles A/B/C held stable before F is sampled; legal range 1..15
//  EXPECTED    8'h30  golden truth table, bit i = F for {A,B,C}=i (devre: F = A & ~B)
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst_n      in   1  synchronous, active-low reset
//  start      in   1  sweep request; sampled only in IDLE
//  abort      in   1  cancels sweep/eval in progress
//  eval_req   in   1  single-vector request; level, held until eval_ack
//  eval_vec   in   3  {A,B,C} for single evaluation; captured when request granted
//  f_i        in   1  F from devre instance
//  abc_o      out  3  {A,B,C} to devre instance
//  busy       out  1  high in any non-IDLE state
//  done       out  1  1-cycle pulse, sweep completed normally
//  table_o    out  8  captured truth table, bit i = F at vector i
//  pass       out  1  table_o == EXPECTED; valid from done, held until next start
//  eval_ack   out  1  1-cycle pulse, eval_f valid this cycle
//  eval_f     out  1  F for last granted eval_vec; held until next ack
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; abc_o=0, busy=0, done=0, table_o=0, pass=0, eval_ack=0, eval_f=0, idx=0, cnt=0. Applies mid-operation; no done/ack emitted.
//  States: IDLE, SETTLE, SAMPLE, DONE; mode flag SWEEP/EVAL set on grant.
//  IDLE: abc_o=0. Grant priority: start > eval_req. start&eval_req same cycle -> sweep granted, eval_req stays pending, granted on first IDLE cycle after.
//  Sweep grant: table_o<=0, pass<=0, idx<=0, abc_o<=0, -> SETTLE.
//  Eval grant: abc_o<=eval_vec, -> SETTLE.
//  SETTLE: abc_o stable; lasts exactly SETTLE_CYC cycles (cnt counts 0..SETTLE_CYC-1) -> SAMPLE.
//  SAMPLE (1 cycle): f_i registered at end of cycle.
//   SWEEP: table_o[idx]<=f_i; idx<7 -> idx+1, abc_o<=idx+1, SETTLE; idx==7 -> DONE.
//   EVAL: eval_f<=f_i, eval_ack<=1 next cycle, -> IDLE (ack coincides with first IDLE cycle).
//  DONE (1 cycle): done=1, pass=(table_o==EXPECTED); -> IDLE.
//  Sweep latency: start sampled at edge 0 -> done high in cycle 8*(SETTLE_CYC+1)+1 (25 at default).
//  Eval latency: grant edge 0 -> eval_ack high in cycle SETTLE_CYC+2 (4 at default).
//  start/eval_req while busy: ignored (start not queued; eval_req waits as level).
//  abort in SETTLE/SAMPLE: -> IDLE next edge; no done, no eval_ack; table_o keeps bits captured so far, pass=0. abort in IDLE/DONE: no effect (DONE completes).
//  idx is 3-bit, never wraps: sweep ends at 7. cnt width 4 bits.
// STRUCTURE
//  Package devre_ctrl_pkg: state enum {IDLE,SETTLE,SAMPLE,DONE}, mode enum {SWEEP,EVAL}, NUM_VEC=8, DEVRE_GOLDEN=8'h30.
//  Sub-module devre_settle_timer: load/run, counts SETTLE_CYC cycles, emits expire; FSM otherwise flat in this module.
// TESTING (bench instantiates real devre on abc_o/f_i)
//  1. Reset then start pulse, default params -> done in cycle 25, table_o=8'h30, pass=1, busy high cycles 1..25.
//  2. EXPECTED=8'h31, start -> table_o=8'h30, pass=0, done still pulses once.
//  3. eval_req with eval_vec=3'b100 -> abc_o=100 for 3 cycles, eval_ack cycle 4, eval_f=1; eval_vec=3'b110 -> eval_f=0.
//  4. start and eval_req(3'b101) same cycle -> sweep runs first, done cycle 25, eval_ack 4 cycles after first IDLE, eval_f=1.
//  5. abort during vector 5 SETTLE -> IDLE next cycle, no done, table_o=8'h30 masked to bits 0..4 (8'h10), pass=0; new start then completes normally.
//  6. rst_n=0 for one edge mid-sweep and mid-eval -> all outputs zero, no done/eval_ack; SETTLE_CYC=1 sweep -> done cycle 17.

Source files
------------

// File: rtl/devre_sweep_ctrl_pkg.sv
// Shared types and constants for the devre sweep controller and its settle timer.
package devre_ctrl_pkg;

  localparam int unsigned NUM_VEC      = 8;
  localparam logic [7:0]  DEVRE_GOLDEN = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef enum logic {
    SWEEP,
    EVAL
  } mode_t;

endpackage

// File: rtl/devre_sweep_ctrl_if.sv
// Host-side request/response bundle of the devre sweep controller.
interface devre_sweep_ctrl_if;

  logic       start;
  logic       abort;
  logic       eval_req;
  logic [2:0] eval_vec;
  logic       busy;
  logic       done;
  logic [7:0] table_o;
  logic       pass;
  logic       eval_ack;
  logic       eval_f;

  modport master (
    output start, abort, eval_req, eval_vec,
    input  busy, done, table_o, pass, eval_ack, eval_f
  );

  modport slave (
    input  start, abort, eval_req, eval_vec,
    output busy, done, table_o, pass, eval_ack, eval_f
  );

endinterface

// File: rtl/devre_sweep_ctrl_settle_timer.sv
// Settle down-counter: load arms it, expire flags the last settle cycle.
module devre_settle_timer #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYC - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 4'd0);

endmodule

// File: rtl/devre_sweep_ctrl.sv
// Owner of the devre A/B/C inputs: full truth-table sweep or single-vector evaluation.
//
//   state  | meaning
//   IDLE   | abc_o parked at 0, waiting for start (priority) or eval_req
//   SETTLE | abc_o held for SETTLE_CYC cycles so F can settle
//   SAMPLE | F captured into table_o (sweep) or eval_f (eval)
//   DONE   | sweep finished, done pulses, pass valid
module devre_sweep_ctrl
  import devre_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  EXPECTED   = DEVRE_GOLDEN
) (
  input  logic               clk,
  input  logic               rst_n,
  devre_sweep_ctrl_if.slave  host,
  input  logic               f_i,
  output logic [2:0]         abc_o
);

  state_t     state_q, state_d;
  mode_t      mode_q, mode_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] table_q, table_d;
  logic       pass_q, pass_d;
  logic       eval_ack_q, eval_ack_d;
  logic       eval_f_q, eval_f_d;

  logic timer_load;
  logic timer_run;
  logic timer_expire;

  devre_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .run    (timer_run),
    .expire (timer_expire)
  );

  assign timer_run = (state_q == SETTLE);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    abc_d      = abc_q;
    table_d    = table_q;
    pass_d     = pass_q;
    eval_ack_d = 1'b0;
    eval_f_d   = eval_f_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE: begin
        abc_d = 3'd0;
        if (host.start) begin
          mode_d     = SWEEP;
          table_d    = 8'd0;
          pass_d     = 1'b0;
          idx_d      = 3'd0;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end else if (host.eval_req) begin
          mode_d     = EVAL;
          abc_d      = host.eval_vec;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (host.abort) begin
          abc_d   = 3'd0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (host.abort) begin
          abc_d   = 3'd0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (mode_q == SWEEP) begin
          table_d[idx_q] = f_i;
          if (idx_q == 3'(NUM_VEC - 1)) begin
            // pass must already be valid in the DONE cycle, so judge the table including this bit
            pass_d  = (table_d == EXPECTED);
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 3'd1;
            abc_d      = idx_q + 3'd1;
            timer_load = 1'b1;
            state_d    = SETTLE;
          end
        end else begin
          eval_f_d   = f_i;
          eval_ack_d = 1'b1;
          abc_d      = 3'd0;
          state_d    = IDLE;
        end
      end

      DONE: begin
        abc_d   = 3'd0;
        state_d = IDLE;
      end

      default: begin
        abc_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= SWEEP;
      idx_q      <= 3'd0;
      abc_q      <= 3'd0;
      table_q    <= 8'd0;
      pass_q     <= 1'b0;
      eval_ack_q <= 1'b0;
      eval_f_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      abc_q      <= abc_d;
      table_q    <= table_d;
      pass_q     <= pass_d;
      eval_ack_q <= eval_ack_d;
      eval_f_q   <= eval_f_d;
    end
  end

  assign abc_o         = abc_q;
  assign host.busy     = (state_q != IDLE);
  assign host.done     = (state_q == DONE);
  assign host.table_o  = table_q;
  assign host.pass     = pass_q;
  assign host.eval_ack = eval_ack_q;
  assign host.eval_f   = eval_f_q;

endmodule

// File: tb/tb_devre_sweep_ctrl.sv
// Bench for devre_sweep_ctrl: three parameterisations checked every cycle against a timeline model.
module tb_devre_sweep_ctrl;

  localparam int NI = 3;
  localparam int SC [NI] = '{2, 2, 1};
  localparam logic [7:0] EX [NI] = '{8'h30, 8'h31, 8'h30};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st [NI];
  logic       ab [NI];
  logic       er [NI];
  logic [2:0] ev [NI];

  logic [2:0] abc_w  [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic [7:0] tab_w  [NI];
  logic       pass_w [NI];
  logic       ack_w  [NI];
  logic       evf_w  [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    devre_sweep_ctrl_if u_if ();
    logic [2:0] abc;
    logic       f;

    // the devre network itself: F = A & ~B
    assign f = abc[2] & ~abc[1];

    assign u_if.start    = st[g];
    assign u_if.abort    = ab[g];
    assign u_if.eval_req = er[g];
    assign u_if.eval_vec = ev[g];

    devre_sweep_ctrl #(
      .SETTLE_CYC (SC[g]),
      .EXPECTED   (EX[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (u_if),
      .f_i   (f),
      .abc_o (abc)
    );

    assign abc_w[g]  = abc;
    assign busy_w[g] = u_if.busy;
    assign done_w[g] = u_if.done;
    assign tab_w[g]  = u_if.table_o;
    assign pass_w[g] = u_if.pass;
    assign ack_w[g]  = u_if.eval_ack;
    assign evf_w[g]  = u_if.eval_f;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: an operation is active for m_e = 1..length cycles after its grant edge
  bit         m_act  [NI];
  bit         m_sw   [NI];
  int         m_e    [NI];
  logic [2:0] m_vec  [NI];
  logic [7:0] m_tab  [NI];
  bit         m_pass [NI];
  bit         m_evf  [NI];
  bit         m_ack  [NI];

  int o_dat [NI];
  int o_dn  [NI];
  int o_aat [NI];
  int o_bn  [NI];
  int o_tn  [NI];

  function automatic logic devre_f(input logic [2:0] v);
    return v[2] & ~v[1];
  endfunction

  function automatic int sweep_len(input int i);
    return 8 * (SC[i] + 1) + 1;
  endfunction

  function automatic bit abort_ok(input int i);
    if (!m_act[i]) return 1'b1;
    if (!m_sw[i]) return 1'b0;
    if (m_e[i] == sweep_len(i)) return 1'b1;
    return ((m_e[i] - 1) % (SC[i] + 1)) != SC[i];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int s;
      int k;
      bit ack_n;
      s     = SC[i];
      ack_n = 1'b0;
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_tab[i]  = 8'd0;
        m_pass[i] = 1'b0;
        m_evf[i]  = 1'b0;
      end else if (!m_act[i]) begin
        if (st[i]) begin
          m_act[i]  = 1'b1;
          m_sw[i]   = 1'b1;
          m_e[i]    = 1;
          m_tab[i]  = 8'd0;
          m_pass[i] = 1'b0;
        end else if (er[i]) begin
          m_act[i] = 1'b1;
          m_sw[i]  = 1'b0;
          m_e[i]   = 1;
          m_vec[i] = ev[i];
        end
      end else if (m_sw[i]) begin
        if (m_e[i] == sweep_len(i)) begin
          m_act[i] = 1'b0;
        end else if (ab[i]) begin
          m_act[i]  = 1'b0;
          m_pass[i] = 1'b0;
        end else begin
          k = (m_e[i] - 1) / (s + 1);
          if (((m_e[i] - 1) % (s + 1)) == s) begin
            m_tab[i][k] = devre_f(3'(k));
            if (k == 7) m_pass[i] = (m_tab[i] == EX[i]);
          end
          m_e[i]++;
        end
      end else begin
        if (ab[i]) begin
          m_act[i]  = 1'b0;
          m_pass[i] = 1'b0;
        end else if (m_e[i] == s + 1) begin
          m_evf[i] = devre_f(m_vec[i]);
          ack_n    = 1'b1;
          m_act[i] = 1'b0;
        end else begin
          m_e[i]++;
        end
      end
      m_ack[i] = ack_n;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      int s;
      int l;
      s = SC[i];
      l = sweep_len(i);
      chk($sformatf("i%0d busy", i), 32'(busy_w[i]), 32'(m_act[i]));
      chk($sformatf("i%0d done", i), 32'(done_w[i]), 32'(m_act[i] && m_sw[i] && (m_e[i] == l)));
      if (!m_act[i])
        chk($sformatf("i%0d abc idle", i), 32'(abc_w[i]), 32'd0);
      else if (!m_sw[i])
        chk($sformatf("i%0d abc eval", i), 32'(abc_w[i]), 32'(m_vec[i]));
      else if (m_e[i] < l)
        chk($sformatf("i%0d abc sweep", i), 32'(abc_w[i]), 32'((m_e[i] - 1) / (s + 1)));
      chk($sformatf("i%0d table", i), 32'(tab_w[i]), 32'(m_tab[i]));
      chk($sformatf("i%0d pass", i), 32'(pass_w[i]), 32'(m_pass[i]));
      chk($sformatf("i%0d eval_ack", i), 32'(ack_w[i]), 32'(m_ack[i]));
      chk($sformatf("i%0d eval_f", i), 32'(evf_w[i]), 32'(m_evf[i]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  // cycle n of the window is the n-th cycle after the most recent edge
  task automatic obs(input int ncyc, input logic [2:0] tgt);
    for (int i = 0; i < NI; i++) begin
      o_dat[i] = 0; o_dn[i] = 0; o_aat[i] = 0; o_bn[i] = 0; o_tn[i] = 0;
    end
    for (int n = 1; n <= ncyc; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (done_w[i] === 1'b1) begin
          o_dn[i]++;
          if (o_dat[i] == 0) o_dat[i] = n;
        end
        if (ack_w[i] === 1'b1) begin
          if (o_aat[i] == 0) o_aat[i] = n;
          er[i] = 1'b0;
        end
        if (busy_w[i] === 1'b1) o_bn[i]++;
        if (busy_w[i] === 1'b1 && abc_w[i] === tgt) o_tn[i]++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; er[i] = 1'b0; ev[i] = 3'd0;
      m_act[i] = 1'b0; m_sw[i] = 1'b0; m_e[i] = 0; m_vec[i] = 3'd0;
      m_tab[i] = 8'd0; m_pass[i] = 1'b0; m_evf[i] = 1'b0; m_ack[i] = 1'b0;
    end
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset table", 32'(tab_w[0]), 32'd0);

    // full sweeps on all three parameterisations
    for (int i = 0; i < NI; i++) st[i] = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    obs(40, 3'b111);
    chk("sweep done cycle", 32'(o_dat[0]), 32'd25);
    chk("sweep done count", 32'(o_dn[0]), 32'd1);
    chk("sweep busy cycles", 32'(o_bn[0]), 32'd25);
    chk("sweep table", 32'(tab_w[0]), 32'h30);
    chk("sweep pass", 32'(pass_w[0]), 32'd1);
    chk("bad golden done cycle", 32'(o_dat[1]), 32'd25);
    chk("bad golden done count", 32'(o_dn[1]), 32'd1);
    chk("bad golden table", 32'(tab_w[1]), 32'h30);
    chk("bad golden pass", 32'(pass_w[1]), 32'd0);
    chk("settle1 done cycle", 32'(o_dat[2]), 32'd17);
    chk("settle1 busy cycles", 32'(o_bn[2]), 32'd17);

    // single evaluations
    er[0] = 1'b1; ev[0] = 3'b100;
    tick();
    obs(10, 3'b100);
    chk("eval100 ack cycle", 32'(o_aat[0]), 32'd4);
    chk("eval100 abc cycles", 32'(o_tn[0]), 32'd3);
    chk("eval100 f", 32'(evf_w[0]), 32'd1);
    er[0] = 1'b1; ev[0] = 3'b110;
    tick();
    obs(10, 3'b110);
    chk("eval110 ack cycle", 32'(o_aat[0]), 32'd4);
    chk("eval110 f", 32'(evf_w[0]), 32'd0);

    // start and eval_req together: sweep first, eval on the first idle cycle
    st[0] = 1'b1; er[0] = 1'b1; ev[0] = 3'b101;
    tick();
    st[0] = 1'b0;
    obs(40, 3'b101);
    chk("collide done cycle", 32'(o_dat[0]), 32'd25);
    chk("collide ack cycle", 32'(o_aat[0]), 32'd30);
    chk("collide eval f", 32'(evf_w[0]), 32'd1);

    // abort while vector 5 settles
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int n = 0; n < 15; n++) tick();
    chk("abort point abc", 32'(abc_w[0]), 32'd5);
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk("abort busy", 32'(busy_w[0]), 32'd0);
    chk("abort table", 32'(tab_w[0]), 32'h10);
    chk("abort pass", 32'(pass_w[0]), 32'd0);
    obs(30, 3'b111);
    chk("abort no done", 32'(o_dn[0]), 32'd0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    obs(40, 3'b111);
    chk("restart done cycle", 32'(o_dat[0]), 32'd25);
    chk("restart table", 32'(tab_w[0]), 32'h30);

    // reset mid-sweep and mid-eval
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst sweep busy", 32'(busy_w[0]), 32'd0);
    chk("rst sweep table", 32'(tab_w[0]), 32'd0);
    chk("rst sweep abc", 32'(abc_w[0]), 32'd0);
    chk("rst sweep eval_f", 32'(evf_w[0]), 32'd0);
    obs(40, 3'b111);
    chk("rst sweep no done", 32'(o_dn[0]), 32'd0);
    er[0] = 1'b1; ev[0] = 3'b100;
    tick();
    tick();
    rst_n = 1'b0; er[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    obs(10, 3'b100);
    chk("rst eval no ack", 32'(o_aat[0]), 32'd0);
    chk("rst eval busy", 32'(o_bn[0]), 32'd0);
    chk("rst eval f", 32'(evf_w[0]), 32'd0);

    // randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NI; i++) begin
        st[i] = ($urandom_range(0, 24) == 0);
        if (er[i] && (ack_w[i] === 1'b1)) begin
          er[i] = 1'b0;
        end else if (!er[i] && ($urandom_range(0, 7) == 0)) begin
          er[i] = 1'b1;
          ev[i] = 3'($urandom);
        end
        ab[i] = abort_ok(i) && ($urandom_range(0, 29) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
